traffic_gen_kernel_seq: RTL
===========================

TRAFFIC_GEN_KERNEL_SEQ -- requirements
Module: traffic_gen_kernel_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of request, beat and timeout counters.
REQ-002 SHALL have parameter ITER_W, default 16: width of iteration count.
REQ-003 SHALL have ports: clk_i in 1, single clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_i in 1, reset, synchronous, active-high.
REQ-005 SHALL have ports: clear_i in 1, synchronous soft clear.
REQ-006 SHALL have cfg ports: cfg_valid_i in 1, job request; cfg_ready_o out 1, job accept.
REQ-007 SHALL have cfg data ports: cfg_n_total_reqs_i, cfg_t_ck_reqs_i, cfg_t_ck_idle_i, cfg_timeout_i, all in CNT_W; cfg_n_iters_i in ITER_W.
REQ-008 SHALL have kernel parameter ports: k_n_total_reqs_o, k_t_ck_reqs_o, k_t_ck_idle_o, all out CNT_W.
REQ-009 SHALL have kernel control ports: k_start_o out 1 (ap_start), k_done_i in 1 (ap_done), k_ready_i in 1 (ap_ready), k_idle_i in 1 (ap_idle, status only).
REQ-010 SHALL have stream monitor ports: w_valid_i in 1, w_ready_i in 1, both taps of the kernel write-request stream.
REQ-011 SHALL have status ports: busy_o out 1, evt_done_o out 1 (pulse), err_timeout_o out 1, err_count_o out 1, iter_cnt_o out ITER_W, beat_cnt_o out CNT_W.

Function
REQ-012 SHALL implement FSM states IDLE, START, RUN, DONE; reset state IDLE.
REQ-013 IDLE: cfg_ready_o=1, busy_o=0; all other states cfg_ready_o=0, busy_o=1.
REQ-014 IDLE, cfg_valid_i=1: latch all cfg_* inputs; clear err_timeout_o, err_count_o, iter_cnt_o, beat_cnt_o, timeout counter; go to START, or to DONE if cfg_n_iters_i=0 (no kernel start).
REQ-015 k_*_o parameter outputs SHALL be the latched values, stable from accept until next accept.
REQ-016 START: k_start_o=1 (registered, asserted first cycle in START), held until k_ready_i=1 sampled; then go to RUN.
REQ-017 RUN: k_start_o=0; wait k_done_i=1.
REQ-018 Completion (k_done_i=1 in RUN, or k_done_i=1 with k_ready_i=1 in START) SHALL increment iter_cnt_o and set err_count_o (sticky) if beat_cnt_o, including a beat in that same cycle, differs from latched n_total_reqs.
REQ-019 After completion: if iter_cnt_o+1 equals latched n_iters go to DONE; else go to START, clearing beat_cnt_o and the timeout counter.
REQ-020 beat_cnt_o SHALL increment on each cycle with w_valid_i&w_ready_i in START or RUN; saturate at all-ones; beats in IDLE/DONE ignored.
REQ-021 Timeout counter SHALL increment every cycle in START/RUN; reset on each START entry; when latched timeout is nonzero and counter equals it with no completion that cycle, set err_timeout_o (sticky), drop k_start_o, go to DONE; timeout 0 disables.
REQ-022 Completion and timeout in same cycle: completion wins, no error.
REQ-023 DONE: evt_done_o=1 for exactly one cycle; next state IDLE.
REQ-024 Latency: cfg accept to first k_start_o=1 is 1 cycle; final k_done_i to evt_done_o is 1 cycle.
REQ-025 k_idle_i SHALL not affect state transitions.

Reset
REQ-026 rst_i=1 SHALL force IDLE and all outputs and registers to 0 (cfg_ready_o=1 combinationally from IDLE) on the next edge, including mid-job.
REQ-027 clear_i SHALL behave identically to rst_i; rst_i and clear_i both 1 gives the same result.
REQ-028 Reset mid-START SHALL deassert k_start_o on the cycle after the reset edge; no evt_done_o pulse.

Verification
REQ-029 n_iters=3, n_total_reqs=4, kernel replies ready after 2 cycles, done after 4 beats -> three start handshakes, iter_cnt_o=3, evt_done_o one pulse, no errors.
REQ-030 n_iters=1, n_total_reqs=5, kernel emits 4 beats then done -> err_count_o=1, evt_done_o pulse, iter_cnt_o=1.
REQ-031 timeout=10, kernel never asserts k_ready_i -> k_start_o high cycles 1..10, err_timeout_o=1, evt_done_o pulse, back to IDLE.
REQ-032 n_iters=0 -> no k_start_o, evt_done_o 1 cycle after accept, cfg_ready_o back to 1 next cycle.
REQ-033 k_ready_i and k_done_i same cycle in START with timeout reached that cycle -> completion counted, err_timeout_o=0.
REQ-034 rst_i pulse during RUN of iteration 2 -> all outputs 0, IDLE, new job accepted normally afterwards.

Source files
------------

// File: rtl/traffic_gen_kernel_seq.sv
// Job sequencer for an HLS traffic-generator kernel: runs a configured number of
// ap_start/ap_done iterations, counts write beats per iteration and flags errors.
module traffic_gen_kernel_seq #(
    parameter int CNT_W  = 32,
    parameter int ITER_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CNT_W-1:0]  cfg_n_total_reqs_i,
    input  logic [CNT_W-1:0]  cfg_t_ck_reqs_i,
    input  logic [CNT_W-1:0]  cfg_t_ck_idle_i,
    input  logic [CNT_W-1:0]  cfg_timeout_i,
    input  logic [ITER_W-1:0] cfg_n_iters_i,
    output logic [CNT_W-1:0]  k_n_total_reqs_o,
    output logic [CNT_W-1:0]  k_t_ck_reqs_o,
    output logic [CNT_W-1:0]  k_t_ck_idle_o,
    output logic              k_start_o,
    input  logic              k_done_i,
    input  logic              k_ready_i,
    input  logic              k_idle_i,
    input  logic              w_valid_i,
    input  logic              w_ready_i,
    output logic              busy_o,
    output logic              evt_done_o,
    output logic              err_timeout_o,
    output logic              err_count_o,
    output logic [ITER_W-1:0] iter_cnt_o,
    output logic [CNT_W-1:0]  beat_cnt_o
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  n_total_q, t_reqs_q, t_idle_q, timeout_q;
    logic [ITER_W-1:0] n_iters_q, iter_cnt_q;
    logic [CNT_W-1:0]  beat_cnt_q, tmo_cnt_q;
    logic              k_start_q, evt_done_q, err_timeout_q, err_count_q;

    logic              active;
    logic              complete;
    logic              tmo_hit;
    logic [CNT_W-1:0]  beat_cnt_d, tmo_cnt_d;
    logic [ITER_W-1:0] iter_cnt_d;

    // ap_idle is informational only; it never steers the sequencer.
    logic unused_idle;
    assign unused_idle = k_idle_i;

    always_comb begin
        active     = (state_q == START) || (state_q == RUN);
        beat_cnt_d = beat_cnt_q;
        if (active && w_valid_i && w_ready_i && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        tmo_cnt_d  = tmo_cnt_q + CNT_W'(1);
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
        complete   = ((state_q == RUN) && k_done_i) ||
                     ((state_q == START) && k_ready_i && k_done_i);
        tmo_hit    = (timeout_q != '0) && (tmo_cnt_d == timeout_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q       <= IDLE;
            n_total_q     <= '0;
            t_reqs_q      <= '0;
            t_idle_q      <= '0;
            timeout_q     <= '0;
            n_iters_q     <= '0;
            iter_cnt_q    <= '0;
            beat_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            k_start_q     <= 1'b0;
            evt_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        n_total_q     <= cfg_n_total_reqs_i;
                        t_reqs_q      <= cfg_t_ck_reqs_i;
                        t_idle_q      <= cfg_t_ck_idle_i;
                        timeout_q     <= cfg_timeout_i;
                        n_iters_q     <= cfg_n_iters_i;
                        iter_cnt_q    <= '0;
                        beat_cnt_q    <= '0;
                        tmo_cnt_q     <= '0;
                        err_timeout_q <= 1'b0;
                        err_count_q   <= 1'b0;
                        if (cfg_n_iters_i == '0) begin
                            state_q    <= DONE;
                            evt_done_q <= 1'b1;
                        end else begin
                            state_q   <= START;
                            k_start_q <= 1'b1;
                        end
                    end
                end
                START, RUN: begin
                    beat_cnt_q <= beat_cnt_d;
                    tmo_cnt_q  <= tmo_cnt_d;
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (complete) begin
                        iter_cnt_q <= iter_cnt_d;
                        if (beat_cnt_d != n_total_q) begin
                            err_count_q <= 1'b1;
                        end
                        if (iter_cnt_d == n_iters_q) begin
                            state_q    <= DONE;
                            k_start_q  <= 1'b0;
                            evt_done_q <= 1'b1;
                        end else begin
                            state_q    <= START;
                            k_start_q  <= 1'b1;
                            beat_cnt_q <= '0;
                            tmo_cnt_q  <= '0;
                        end
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        k_start_q     <= 1'b0;
                        state_q       <= DONE;
                        evt_done_q    <= 1'b1;
                    end else if ((state_q == START) && k_ready_i) begin
                        state_q   <= RUN;
                        k_start_q <= 1'b0;
                    end
                end
                DONE: begin
                    evt_done_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o      = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign k_n_total_reqs_o = n_total_q;
    assign k_t_ck_reqs_o    = t_reqs_q;
    assign k_t_ck_idle_o    = t_idle_q;
    assign k_start_o        = k_start_q;
    assign evt_done_o       = evt_done_q;
    assign err_timeout_o    = err_timeout_q;
    assign err_count_o      = err_count_q;
    assign iter_cnt_o       = iter_cnt_q;
    assign beat_cnt_o       = beat_cnt_q;

endmodule
